uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of the configurable `uart` transmitter. Host logic pushes bytes at full clock rate. The block stores them in a circular FIFO and drives the UART's `tx_start`/`data_in` handshake, one byte per frame. It also tracks the UART's `tx_busy` so consecutive frames go out back-to-back without host involvement.

## Interface
Parameters:
- `DEPTH`, 8, number of byte entries; power of two, at least 2.
- `AW`, `$clog2(DEPTH)`, pointer width (derived, not overridden).

Ports:
- `clk` input 1: single clock, shared with `uart`.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: push request, one byte per cycle.
- `wr_data` input 8: byte to push.
- `flush` input 1: synchronous discard of all queued bytes.
- `baud_en` input 1: same bit-rate enable that drives `uart.baud_en`.
- `tx_busy` input 1: from `uart.tx_busy`.
- `tx_start` output 1: to `uart.tx_start`.
- `data_out` output 8: to `uart.data_in`.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output AW+1: number of queued bytes, 0..DEPTH.
- `overflow` output 1: one-cycle pulse when a push is dropped.

## Operation
- Storage: DEPTH x 8 array, with `wr_ptr`/`rd_ptr` (AW bits) and `count` (AW+1 bits). Pointers wrap modulo DEPTH naturally.
- Push is accepted when `wr_en && (!full || pop)` and `!flush`. It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Push while full without a same-cycle pop: the byte is dropped and `overflow` pulses high for 1 cycle. `count` is unchanged.
- Pop occurs only on the handshake edge (see REQ). Pop increments `rd_ptr`.
- `count` update rules:
  - push+pop in the same cycle leaves `count` unchanged;
  - push only adds 1;
  - pop only subtracts 1.
- `flush`:
  - clears `count` to 0 and sets `rd_ptr` = `wr_ptr`;
  - wins over a same-cycle push; that byte is discarded and `overflow` does not pulse;
  - does not abort a frame already accepted by the UART.
- `full`, `empty` and `count` are registered and consistent with each other every cycle.

Feeder FSM, three states:
- IDLE: `tx_start`=0.
  - When `!empty && !tx_busy && !flush`: load `data_out` <= `mem[rd_ptr]` and go to REQ.
- REQ: `tx_start`=1, `data_out` held stable.
  - Handshake condition is `baud_en && !tx_busy`. This is the exact edge on which `uart` latches `data_in`.
  - On the handshake: pop and go to SEND.
  - `flush` in REQ (no handshake that cycle): go to IDLE, `tx_start` drops, nothing is popped.
  - `flush` coinciding with a handshake: the pop completes, the remaining bytes are flushed, and the FSM goes to SEND.
- SEND: `tx_start`=0.
  - Wait until `tx_busy`==0 sampled at a clock edge, then go to IDLE.
  - `tx_busy` is guaranteed high on the cycle after the handshake because the UART registers it.
- Exactly one `tx_start` handshake is made per queued byte. Bytes go out in push order.

## Timing
- Reset values (asynchronous): state IDLE, `tx_start`=0, `data_out`=8'h00, `full`=0, `empty`=1, `count`=0, `overflow`=0, both pointers 0. Memory contents are not reset.
- Push at edge N: `count`/`empty` update after N.
- If the UART is idle, IDLE moves to REQ at edge N+1, so `tx_start` is high from N+1.
- `tx_start` stays high until the first cycle with `baud_en`=1 and `tx_busy`=0. It drops on the following edge.
- Inter-frame gap: `tx_busy` falls, then IDLE (1 clk), then REQ (1 clk), then waiting for the next `baud_en`. This gives at most one extra baud period between stop bit and next start bit.
- `overflow` is registered and asserted on the cycle after the dropped push.
- Reset mid-frame returns every output to its reset value immediately; queued bytes are lost.

## Test plan
- Reset, then push 8'hA5 with `baud_en` pulsing every 4 clks and the UART model idle. Required: `tx_start` high 1 clk after the push; one handshake with `data_out`=8'hA5; `count` goes 1 -> 0 on the handshake edge; `empty`=1 afterwards.
- Push 8'h01..8'h08 on consecutive cycles (DEPTH=8) while `tx_busy`=1. Required: `count`=8 and `full`=1; a 9th push of 8'hFF gives a 1-cycle `overflow` with `count` still 8. Then release `tx_busy`: bytes emerge in order 01..08 and 8'hFF never appears.
- With the FIFO full, push on the same cycle as a handshake pop. Required: the push is accepted, `count` stays 8, and `overflow` stays 0.
- Push three bytes with `tx_busy` high, assert `flush` for 1 cycle. Required: `count`=0 and `empty`=1; no `tx_start` follows. A flush during REQ drops `tx_start` on the next cycle with no pop.
- Assert `rst` while in REQ and again in SEND with 5 bytes queued. Required: `tx_start`=0, `count`=0, `empty`=1 and `data_out`=8'h00 immediately, without waiting for a clock edge.
- Push 200 random bytes at random times into the real `uart` (8N1 configuration). Required: the serial output decodes to the identical byte sequence with no gaps longer than one baud period between frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter's tx_start/data_in handshake
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          baud_en,
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    data_out,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  data_out_q, data_out_d;
  state_t      state_q, state_d;
  logic        push, pop;

  always_comb begin
    pop  = (state_q == S_REQ) && baud_en && !tx_busy;
    push = wr_en && !flush && (!full_q || pop);
    overflow_d = wr_en && !flush && full_q && !pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    // A flush never coincides with an accepted push, so wr_ptr_q is the final write pointer.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end

    full_d  = (count_d == COUNT_FULL);
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    tx_start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_q && !tx_busy && !flush) begin
          data_out_d = mem_q[rd_ptr_q];
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        tx_start = 1'b1;
        if (pop) begin
          state_d = S_SEND;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_out_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_out = data_out_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural 8N1 UART and serial decoder
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, wr_en, flush, baud_en, tx_busy, tx_start, full, empty, overflow;
  logic [7:0] wr_data, data_out;
  logic [3:0] count;

  logic hold, baud_on, gap_chk, chk_on;
  int   n_checks = 0, n_fail = 0, n_hs = 0, idle_run = 0, bcnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] ser_q[$];
  logic       exp_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .baud_en(baud_en), .tx_busy(tx_busy), .tx_start(tx_start), .data_out(data_out),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Baud tick every 4 clocks, changed on the falling edge.
  always @(negedge clk) begin
    bcnt++;
    baud_en = baud_on && (bcnt % 4 == 3);
  end

  // Behavioural 8N1 transmitter: latch on handshake, 10 baud periods busy.
  logic       uart_busy, txd;
  logic [8:0] sh;
  int         nb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_busy <= 1'b0; txd <= 1'b1; sh <= '0; nb <= 0;
    end else if (!uart_busy) begin
      if (tx_start && baud_en && !tx_busy) begin
        uart_busy <= 1'b1; txd <= 1'b0; sh <= {1'b1, data_out}; nb <= 9;
      end
    end else if (baud_en) begin
      if (nb > 0) begin
        txd <= sh[0]; sh <= sh >> 1; nb <= nb - 1;
      end else begin
        uart_busy <= 1'b0;
      end
    end
  end
  assign tx_busy = uart_busy | hold;

  // Serial line decoder, sampling once per baud tick.
  int         dstate;
  logic [7:0] dsh;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate = 0;
    end else if (baud_en) begin
      if (dstate == 0) begin
        if (txd == 1'b0) dstate = 1;
      end else if (dstate <= 8) begin
        dsh = {txd, dsh[7:1]};
        dstate++;
      end else begin
        check("stop_bit", txd, 1);
        if (ser_q.size() == 0) check("serial_unexpected_byte", dsh, 32'hffff_ffff);
        else check("serial_byte", dsh, ser_q.pop_front());
        dstate = 0;
      end
    end
  end

  // Monitor and reference model: handshakes pop the expected queue, pushes follow FIFO rules.
  always @(posedge clk) begin
    if (!rst) begin
      automatic logic hs = tx_start && baud_en && !tx_busy;
      if (gap_chk && !hs && !tx_busy && exp_q.size() > 0) idle_run++;
      if (hs) begin
        n_hs++;
        if (gap_chk) check("frame_gap_bound", idle_run <= 5, 1);
        idle_run = 0;
        if (exp_q.size() == 0) check("unexpected_handshake", data_out, 32'hffff_ffff);
        else begin
          automatic logic [7:0] e = exp_q.pop_front();
          check("handshake_data", data_out, e);
          ser_q.push_back(e);
        end
      end
      exp_ovf = 1'b0;
      if (flush) exp_q.delete();
      else if (wr_en) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(wr_data);
        else exp_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      check("count", count, exp_q.size());
      check("full", full, exp_q.size() == DEPTH);
      check("empty", empty, exp_q.size() == 0);
      check("overflow", overflow, exp_ovf);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int i = 0;
    while (i < lim && !(exp_q.size() == 0 && !tx_busy && !tx_start)) begin
      step();
      i++;
    end
    check(nm, i < lim, 1);
  endtask

  task automatic wait_tx_start(input string nm);
    int i = 0;
    while (i < 20 && !tx_start) begin
      step();
      i++;
    end
    check(nm, tx_start, 1);
  endtask

  task automatic async_reset_check(input string nm);
    #2 rst = 1'b1;
    exp_q.delete(); ser_q.delete(); exp_ovf = 1'b0;
    #1;
    check({nm, "_tx_start"}, tx_start, 0);
    check({nm, "_count"}, count, 0);
    check({nm, "_empty"}, empty, 1);
    check({nm, "_data_out"}, data_out, 8'h00);
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int hs_before, starts;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    hold = 1'b0; baud_on = 1'b1; gap_chk = 1'b0; chk_on = 1'b1;
    repeat (3) step();
    check("rst_tx_start", tx_start, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    step();

    // Single byte: tx_start rises one clock after the push edge.
    push(8'hA5);
    check("tx_start_not_yet", tx_start, 0);
    step();
    check("tx_start_after_push", tx_start, 1);
    wait_drain(200, "drain_single");
    check("single_handshakes", n_hs, 1);

    // Fill while the UART is busy, overflow once, then push on a handshake edge.
    hold = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("filled_count", count, 8);
    check("filled_full", full, 1);
    push(8'hFF);
    check("overflow_pulse", overflow, 1);
    check("overflow_count", count, 8);
    step();
    check("overflow_one_cycle", overflow, 0);
    hold = 1'b0;
    begin
      int i = 0;
      while (i < 100 && !(tx_start && baud_en && !tx_busy)) begin
        step();
        i++;
      end
      check("found_full_handshake", i < 100, 1);
    end
    push(8'h99);
    check("push_pop_full_count", count, 8);
    check("push_pop_full_no_overflow", overflow, 0);
    wait_drain(2000, "drain_full");
    check("full_handshakes", n_hs, 10);

    // Flush of queued bytes while the UART is busy.
    hold = 1'b1;
    push(8'hC1); push(8'hC2); push(8'hC3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    hold = 1'b0;
    starts = 0;
    repeat (30) begin
      step();
      if (tx_start) starts++;
    end
    check("no_tx_start_after_flush", starts, 0);

    // Flush while in REQ with no baud tick: tx_start drops, nothing popped.
    baud_on = 1'b0;
    step();
    hs_before = n_hs;
    push(8'h5A);
    wait_tx_start("req_before_flush");
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_req_tx_start", tx_start, 0);
    check("flush_req_count", count, 0);
    check("flush_req_no_pop", n_hs, hs_before);

    // Asynchronous reset in REQ, then in SEND, with five bytes queued.
    for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
    wait_tx_start("req_before_reset");
    async_reset_check("rst_in_req");
    baud_on = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
    begin
      int i = 0;
      while (i < 40 && !uart_busy) begin
        step();
        i++;
      end
      check("send_before_reset", uart_busy, 1);
    end
    step(); step();
    async_reset_check("rst_in_send");

    // Random traffic through the UART model.
    gap_chk = 1'b1;
    for (int n = 0; n < 200; n++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 50)) step();
    end
    wait_drain(5000, "drain_random");
    gap_chk = 1'b0;
    check("serial_all_decoded", ser_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
